// File: rtl/int_arbiter_if.sv
// Register-window bus and CPU interrupt handshake for int_arbiter.
// slave = arbiter side, master = bridge/CPU side.
interface int_arbiter_if #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
);
  logic [N_SRC-1:0] irq_in;
  logic [1:0]       addr;
  logic             WE;
  logic [31:0]      din;
  logic [31:0]      dataOut;
  logic             int_ack;
  logic             int_req;
  logic [ID_W-1:0]  int_id;

  modport slave (
    input  irq_in, addr, WE, din, int_ack,
    output dataOut, int_req, int_id
  );

  modport master (
    output irq_in, addr, WE, din, int_ack,
    input  dataOut, int_req, int_id
  );
endinterface

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt scheduler with mask/pending/status/EOI register window.
// Define INT_ARBITER_EDGE_EN for edge-captured, sticky pending bits (level capture otherwise).
module int_arbiter #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic         clk,
  input  logic         reset,
  int_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  localparam logic [N_SRC-1:0] SRC_ONE = N_SRC'(1);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  sel_id_q, sel_id_d;
  logic             int_req_q, int_req_d;

  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  winner;
  logic             sel_hit;
  logic             wr_mask;
  logic             wr_eoi;
  logic             unused_din;

  assign unused_din = ^bus.din[31:N_SRC];

  assign eligible = pending_q & mask_q;
  assign sel_hit  = |(eligible & (SRC_ONE << sel_id_q));
  assign wr_mask  = bus.WE && (bus.addr == 2'd0);
  assign wr_eoi   = bus.WE && (bus.addr == 2'd3);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

`ifdef INT_ARBITER_EDGE_EN
  logic [N_SRC-1:0] irq_prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c_bits;
  logic [N_SRC-1:0] auto_clr;

  // A fresh edge beats a W1C or auto-clear landing on the same bit.
  always_comb begin
    rise      = bus.irq_in & ~irq_prev_q;
    w1c_bits  = (bus.WE && (bus.addr == 2'd1)) ? bus.din[N_SRC-1:0] : '0;
    auto_clr  = (state_q == REQ && bus.int_ack) ? (SRC_ONE << sel_id_q) : '0;
    pending_d = (pending_q & ~w1c_bits & ~auto_clr) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_prev_q <= '0;
    else       irq_prev_q <= bus.irq_in;
  end
`else
  assign pending_d = bus.irq_in;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sel_id_d = sel_id_q;
    mask_d   = wr_mask ? bus.din[N_SRC-1:0] : mask_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = REQ;
          sel_id_d = winner;
        end
      end
      REQ: begin
        if (bus.int_ack)   state_d = SERVICE;
        else if (!sel_hit) state_d = IDLE;
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    int_req_d = (state_d == REQ);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      sel_id_q  <= '0;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      sel_id_q  <= sel_id_d;
      int_req_q <= int_req_d;
    end
  end

  assign bus.int_req = int_req_q;
  assign bus.int_id  = sel_id_q;

  always_comb begin
    bus.dataOut = '0;
    unique case (bus.addr)
      2'd0: bus.dataOut = 32'(mask_q);
      2'd1: bus.dataOut = 32'(pending_q);
      2'd2: begin
        bus.dataOut[31]       = (state_q == SERVICE);
        bus.dataOut[ID_W-1:0] = sel_id_q;
      end
      default: bus.dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Randomized + directed bench for int_arbiter against a behavioural reference model.
module tb_int_arbiter;

  localparam int N_SRC = 6;
  localparam int ID_W  = 3;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_SVC  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int_arbiter_if #(.N_SRC(N_SRC), .ID_W(ID_W)) bus ();

  int_arbiter #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit [5:0] m_mask;
  bit [5:0] m_pending;
  bit [5:0] m_prev;
  int       m_phase;
  int       m_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[5:0] = m_mask;
      2'd1: r[5:0] = m_pending;
      2'd2: begin
        r[31]  = (m_phase == PH_SVC);
        r[2:0] = 3'(m_sel);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mask = '0; m_pending = '0; m_prev = '0; m_phase = PH_IDLE; m_sel = 0;
  endtask

  // One rising clock edge of the scheduler, computed from old state.
  task automatic model_clock(input bit [5:0] irq, input logic [1:0] a, input bit we,
                             input logic [31:0] d, input bit ack);
    bit [5:0] elig;
    bit [5:0] p;
    int       phase_n;
    int       lowest;
    elig    = m_pending & m_mask;
    phase_n = m_phase;
    lowest  = -1;
    for (int k = 0; k < 6; k++) if (elig[k] && lowest < 0) lowest = k;
`ifdef INT_ARBITER_EDGE_EN
    p = m_pending;
    if (we && a == 2'd1) p = p & ~d[5:0];
    if (m_phase == PH_REQ && ack) p[m_sel] = 1'b0;
    p = p | (irq & ~m_prev);
`else
    p = irq;
`endif
    if (m_phase == PH_IDLE) begin
      if (lowest >= 0) begin
        phase_n = PH_REQ;
        m_sel   = lowest;
      end
    end else if (m_phase == PH_REQ) begin
      if (ack) phase_n = PH_SVC;
      else if (!elig[m_sel]) phase_n = PH_IDLE;
    end else begin
      if (we && a == 2'd3) phase_n = PH_IDLE;
    end
    if (we && a == 2'd0) m_mask = d[5:0];
    m_pending = p;
    m_prev    = irq;
    m_phase   = phase_n;
  endtask

  // Called at a negedge: drive, check read data, clock, check outputs at next negedge.
  task automatic step(input bit [5:0] irq, input logic [1:0] a, input bit we,
                      input logic [31:0] d, input bit ack);
    bus.irq_in  = irq;
    bus.addr    = a;
    bus.WE      = we;
    bus.din     = d;
    bus.int_ack = ack;
    #1;
    check("dataOut", bus.dataOut, model_read(a));
    @(posedge clk);
    model_clock(irq, a, we, d, ack);
    @(negedge clk);
    check("int_req", 32'(bus.int_req), 32'(m_phase == PH_REQ));
    check("int_id", 32'(bus.int_id), 32'(m_sel));
    bus.WE      = 1'b0;
    bus.int_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_req", 32'(bus.int_req), 32'd0);
    check("rst_id", 32'(bus.int_id), 32'd0);
    bus.addr = 2'd0;
    #1;
    check("rst_mask", bus.dataOut, 32'd0);
    bus.addr = 2'd2;
    #1;
    check("rst_status", bus.dataOut, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit [5:0] irq;
    bus.irq_in = '0; bus.addr = '0; bus.WE = 1'b0; bus.din = '0; bus.int_ack = 1'b0;
    @(negedge clk);
    do_reset();

`ifndef INT_ARBITER_EDGE_EN
    // latency, first request, service and re-request
    step(6'h00, 2'd0, 1'b1, 32'h3F, 1'b0);
    step(6'h01, 2'd2, 1'b0, 32'h0, 1'b0);
    check("lat_cycle1", 32'(bus.int_req), 32'd0);
    step(6'h01, 2'd2, 1'b0, 32'h0, 1'b0);
    check("lat_cycle2", 32'(bus.int_req), 32'd1);
    check("status_req", bus.dataOut, 32'h0);
    step(6'h01, 2'd2, 1'b0, 32'h0, 1'b1);
    check("ack_req", 32'(bus.int_req), 32'd0);
    check("status_svc0", bus.dataOut, 32'h8000_0000);
    step(6'h00, 2'd3, 1'b1, 32'h0, 1'b0);
    step(6'h06, 2'd2, 1'b0, 32'h0, 1'b0);
    step(6'h06, 2'd2, 1'b0, 32'h0, 1'b0);
    check("prio_id", 32'(bus.int_id), 32'd1);
    step(6'h06, 2'd2, 1'b0, 32'h0, 1'b1);
    check("status_svc1", bus.dataOut, 32'h8000_0001);
    step(6'h06, 2'd3, 1'b1, 32'h0, 1'b0);
    step(6'h06, 2'd2, 1'b0, 32'h0, 1'b0);
    check("rereq", 32'(bus.int_req), 32'd1);
    step(6'h06, 2'd2, 1'b0, 32'h0, 1'b1);
    step(6'h00, 2'd3, 1'b1, 32'h0, 1'b0);
    // masked source, then unmask
    step(6'h00, 2'd0, 1'b1, 32'h3E, 1'b0);
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b0);
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b0);
    check("masked", 32'(bus.int_req), 32'd0);
    step(6'h01, 2'd0, 1'b1, 32'h3F, 1'b0);
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b0);
    check("unmasked", 32'(bus.int_req), 32'd1);
    step(6'h00, 2'd0, 1'b0, 32'h0, 1'b1);
    step(6'h00, 2'd3, 1'b1, 32'h0, 1'b0);
    // withdrawal, stray EOI
    step(6'h04, 2'd0, 1'b0, 32'h0, 1'b0);
    step(6'h04, 2'd0, 1'b0, 32'h0, 1'b0);
    check("req_id2", 32'(bus.int_id), 32'd2);
    step(6'h00, 2'd0, 1'b0, 32'h0, 1'b0);
    step(6'h00, 2'd0, 1'b0, 32'h0, 1'b0);
    check("withdrawn", 32'(bus.int_req), 32'd0);
    step(6'h00, 2'd3, 1'b1, 32'h0, 1'b0);
    step(6'h00, 2'd2, 1'b0, 32'h0, 1'b0);
    check("stray_eoi", bus.dataOut, 32'h0000_0002);
    // reset during service
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b0);
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b0);
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(6'h01, 2'd2, 1'b0, 32'h0, 1'b0);
    check("post_rst_quiet", 32'(bus.int_req), 32'd0);
    step(6'h01, 2'd0, 1'b1, 32'h3F, 1'b0);
    step(6'h01, 2'd0, 1'b0, 32'h0, 1'b0);
    check("post_rst_req", 32'(bus.int_req), 32'd1);
`else
    step(6'h00, 2'd0, 1'b1, 32'h3F, 1'b0);
    step(6'h08, 2'd1, 1'b0, 32'h0, 1'b0);
    step(6'h00, 2'd1, 1'b0, 32'h0, 1'b0);
    check("edge_pend", bus.dataOut, 32'h8);
    check("edge_req", 32'(bus.int_req), 32'd1);
    check("edge_id", 32'(bus.int_id), 32'd3);
    step(6'h00, 2'd1, 1'b0, 32'h0, 1'b1);
    check("edge_autoclr", bus.dataOut, 32'h0);
    step(6'h00, 2'd3, 1'b1, 32'h0, 1'b0);
    step(6'h08, 2'd1, 1'b1, 32'h8, 1'b0);
    check("edge_set_wins", bus.dataOut, 32'h8);
    step(6'h00, 2'd1, 1'b1, 32'h8, 1'b0);
    check("edge_w1c", bus.dataOut, 32'h0);
`endif

    // randomized traffic
    irq = '0;
    for (int n = 0; n < 800; n++) begin
      logic [1:0]  a;
      logic [31:0] d;
      bit          we;
      bit          ack;
      if ($urandom_range(0, 249) == 0) do_reset();
`ifdef INT_ARBITER_EDGE_EN
      irq = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
`else
      if ($urandom_range(0, 3) == 0) irq = irq ^ (6'h01 << $urandom_range(0, 5));
`endif
      a   = 2'($urandom_range(0, 3));
      we  = ($urandom_range(0, 3) == 0);
      d   = $urandom;
      if (a == 2'd0 && $urandom_range(0, 1) == 1) d[5:0] = 6'h3F;
      ack = ($urandom_range(0, 3) == 0);
      step(irq, a, we, d, ack);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Interrupt scheduler between the bridge-attached devices (timer0, timer1, spare lines) and the CPU.
- Latches up to six hardware interrupt sources and applies a software mask.
- Selects the highest-priority unmasked source and presents one request at a time to the CPU through a req/ack handshake.
- Holds that source in service until software writes EOI. Programmed as a bridge device through a 4-word register window, same bus shape as the timer.

Parameters:
- N_SRC, 6, number of interrupt sources (maps onto HWInt[7:2]); legal range 1..8.
- ID_W, 3, width of the source index output; must satisfy 2^ID_W >= N_SRC.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- irq_in  input  N_SRC  raw device interrupt lines; bit 0 = HWInt[2] (timer0)
- addr  input  2  word select within register window (DEV_Addr[3:2])
- WE  input  1  register write strobe from bridge, one cycle
- din  input  32  write data
- dataOut  output  32  combinational read data for addr
- int_ack  input  1  one-cycle pulse from CPU on exception entry
- int_req  output  1  interrupt request to CPU
- int_id  output  ID_W  index of requested / in-service source

Behaviour:
- Reset (async, active-high): mask=0, pending=0, state=IDLE, sel_id=0. Outputs int_req=0, int_id=0.
- Registers:
  - addr0 MASK: RW, bits[N_SRC-1:0]; 1 = enabled.
  - addr1 PENDING: R; write 1 clears the bit (W1C).
  - addr2 STATUS: R = {in_service at bit 31, zeros, sel_id in [ID_W-1:0]}; writes ignored.
  - addr3 EOI: write of any value ends service; reads 0.
  - Unused bits read 0.
- Pending capture, level mode (default): pending <= irq_in every cycle. One-cycle latency; W1C has no lasting effect.
- Selection: eligible = pending & mask. Lowest set index wins (fixed priority: timer0 over timer1 over others).
- FSM:
  - IDLE: int_req=0. If eligible != 0, go to REQ and latch sel_id = winner.
  - REQ: int_req=1, int_id=sel_id, frozen even if a higher-priority source appears.
    - On int_ack, go to SERVICE.
    - Otherwise, if eligible[sel_id] drops (source deasserted, masked or cleared), withdraw to IDLE. int_req falls the next cycle.
  - SERVICE: int_req=0, int_id=sel_id, in_service=1. No new request is raised (no nesting). On EOI write, go to IDLE.
- Timing: irq_in rising edge to int_req=1 is 2 cycles (capture, then IDLE->REQ).
- Simultaneous events:
  - int_ack and withdrawal in the same REQ cycle: ack wins.
  - EOI write outside SERVICE: ignored.
  - int_ack outside REQ: ignored.
  - MASK write: takes effect on the following cycle's eligibility.
  - W1C and a new capture on the same bit in the same cycle: set wins.
- Reset asserted mid-REQ or mid-SERVICE: immediate return to IDLE with all registers cleared. No spurious request after release until a source is re-captured.

Optional Feature:
- Macro: INT_ARBITER_EDGE_EN.
- Defined:
  - pending[i] sets on a rising edge of irq_in[i] (registered previous sample).
  - Bit holds until cleared by W1C, or automatically on the REQ->SERVICE transition for sel_id.
  - REQ withdrawal happens only via mask or W1C.
- Undefined: level capture as above; edge register and auto-clear are not built.

Test Plan:
- Reset, MASK=0x3F, irq_in=6'b000001 -> int_req=1 with int_id=0 two cycles later; STATUS reads 0x00000000 before ack.
- irq_in=6'b000110 with MASK=0x3F -> int_id=1. Pulse int_ack -> int_req=0 next cycle, STATUS=0x80000001. Write EOI -> IDLE, then re-request int_id=1 while line held.
- MASK=0x3E, irq_in=6'b000001 -> int_req stays 0. Write MASK=0x3F -> int_req=1 two cycles after the write.
- In REQ with int_id=2, deassert irq_in[2] with no ack -> int_req=0 within 2 cycles, state IDLE. Write EOI -> no effect.
- Assert reset during SERVICE -> int_req=0, int_id=0, MASK reads 0, STATUS reads 0 immediately; held irq_in does not request until MASK is rewritten.
- INT_ARBITER_EDGE_EN: 1-cycle pulse on irq_in[3] -> PENDING=0x8 held, int_req with int_id=3. int_ack -> PENDING=0x0. W1C 0x8 in the same cycle as a new edge -> PENDING stays 0x8.
